// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder controls and ID operands for EX,
// detects load-use hazards, injects bubbles and counts load-use bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic                  RegWrite_i,
  input  logic [3:0]            ALU_op_i,
  input  logic                  ALUSrc_i,
  input  logic                  RegDst_i,
  input  logic                  Branch_i,
  input  logic [1:0]            MemToReg_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [DATA_W-1:0]     pc_plus4_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_sext_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic                  ex_RegWrite_o,
  output logic [3:0]            ex_ALU_op_o,
  output logic                  ex_ALUSrc_o,
  output logic                  ex_RegDst_o,
  output logic                  ex_Branch_o,
  output logic [1:0]            ex_MemToReg_o,
  output logic                  ex_MemRead_o,
  output logic                  ex_MemWrite_o,
  output logic [DATA_W-1:0]     ex_pc_plus4_o,
  output logic [DATA_W-1:0]     ex_rs_data_o,
  output logic [DATA_W-1:0]     ex_rt_data_o,
  output logic [DATA_W-1:0]     ex_imm_sext_o,
  output logic [REG_ADDR_W-1:0] ex_rs_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rt_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [3:0]            alu_op;
    logic                  alu_src;
    logic                  reg_dst;
    logic                  branch;
    logic [1:0]            mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     pc_plus4;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm_sext;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ex_slot_t         ex_q, ex_d, id_slot;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             rt_hit, stall_c;

  // Pack the ID-side inputs into the slot format for a clean capture.
  always_comb begin
    id_slot            = '0;
    id_slot.valid      = 1'b1;
    id_slot.reg_write  = RegWrite_i;
    id_slot.alu_op     = ALU_op_i;
    id_slot.alu_src    = ALUSrc_i;
    id_slot.reg_dst    = RegDst_i;
    id_slot.branch     = Branch_i;
    id_slot.mem_to_reg = MemToReg_i;
    id_slot.mem_read   = MemRead_i;
    id_slot.mem_write  = MemWrite_i;
    id_slot.pc_plus4   = pc_plus4_i;
    id_slot.rs_data    = rs_data_i;
    id_slot.rt_data    = rt_data_i;
    id_slot.imm_sext   = imm_sext_i;
    id_slot.rs_addr    = rs_addr_i;
    id_slot.rt_addr    = rt_addr_i;
    id_slot.rd_addr    = rd_addr_i;
  end

  // Load in EX writing a nonzero register that the ID instruction reads.
  always_comb begin
    rt_hit  = (ex_q.rt_addr == rs_addr_i) | (ex_q.rt_addr == rt_addr_i);
    stall_c = ex_q.valid & ex_q.mem_read & id_valid_i
              & (ex_q.rt_addr != '0) & rt_hit;
  end

  // Priority: flush, hold, load-use bubble, idle bubble, capture.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (stall_c) begin
      ex_d = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (!id_valid_i) begin
      ex_d = '0;
    end else begin
      ex_d = id_slot;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_o       = stall_c;
  assign ex_valid_o    = ex_q.valid;
  assign ex_RegWrite_o = ex_q.reg_write;
  assign ex_ALU_op_o   = ex_q.alu_op;
  assign ex_ALUSrc_o   = ex_q.alu_src;
  assign ex_RegDst_o   = ex_q.reg_dst;
  assign ex_Branch_o   = ex_q.branch;
  assign ex_MemToReg_o = ex_q.mem_to_reg;
  assign ex_MemRead_o  = ex_q.mem_read;
  assign ex_MemWrite_o = ex_q.mem_write;
  assign ex_pc_plus4_o = ex_q.pc_plus4;
  assign ex_rs_data_o  = ex_q.rs_data;
  assign ex_rt_data_o  = ex_q.rt_data;
  assign ex_imm_sext_o = ex_q.imm_sext;
  assign ex_rs_addr_o  = ex_q.rs_addr;
  assign ex_rt_addr_o  = ex_q.rt_addr;
  assign ex_rd_addr_o  = ex_q.rd_addr;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule
